// File: rtl/circle_seg_animator_if.sv
// Display-side bundle for the circle animator: control inputs plus segment/digit/position outputs.
// The master drives the display; the slave supplies enable/dir and observes the rest.
interface circle_seg_animator_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int PW = $clog2(2 * NUM_DIGITS);

  logic                  enable;
  logic                  dir;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic [PW-1:0]         pos;
  logic                  step;

  modport master (
    input  enable,
    input  dir,
    output seg,
    output an,
    output pos,
    output step
  );

  modport slave (
    output enable,
    output dir,
    input  seg,
    input  an,
    input  pos,
    input  step
  );
endinterface

// File: rtl/circle_seg_animator.sv
// Walks a circle around a top/bottom loop over NUM_DIGITS multiplexed 7-seg digits; seg/an are
// registered one cycle after pos/scan state. No backpressure: scan is free-running, animation gated by enable.
module circle_seg_animator #(
  parameter int NUM_DIGITS     = 4,
  parameter int STEP_DIV       = 25000000,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  circle_seg_animator_if.master bus
);

  localparam int PW = $clog2(2 * NUM_DIGITS);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] POS_LAST  = PW'(2 * NUM_DIGITS - 1);
  localparam logic [PW-1:0] POS_NDIG  = PW'(NUM_DIGITS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  localparam logic [7:0] PAT_HIGH = 8'b0110_0011;
  localparam logic [7:0] PAT_LOW  = 8'b0101_1100;
  localparam logic [7:0] PAT_OFF  = 8'h00;

  localparam logic [7:0]            SEG_XOR = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_XOR  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [SW-1:0]         step_cnt;
  logic [CW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic [PW-1:0]         pos_q;
  logic                  step_q;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                  tick;
  logic                  scan_wrap;
  logic [PW-1:0]         pos_nxt;
  logic [PW-1:0]         idx_ext;
  logic                  hi_hit;
  logic                  lo_hit;
  logic [7:0]            pat;
  logic [NUM_DIGITS-1:0] an_hot;

  always_comb begin
    tick      = bus.enable && (step_cnt == STEP_LAST);
    scan_wrap = (scan_cnt == SCAN_LAST);

    pos_nxt = pos_q;
    if (bus.dir) begin
      pos_nxt = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
    end else begin
      pos_nxt = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
    end

    // Top row runs left to right; the bottom row maps back right to left.
    idx_ext = PW'(scan_idx);
    hi_hit  = (pos_q < POS_NDIG) && (pos_q == idx_ext);
    lo_hit  = (pos_q >= POS_NDIG) && ((POS_LAST - pos_q) == idx_ext);

    pat = PAT_OFF;
    if (bus.enable) begin
      if (hi_hit) begin
        pat = PAT_HIGH;
      end else if (lo_hit) begin
        pat = PAT_LOW;
      end
    end

    an_hot = NUM_DIGITS'(1) << scan_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      scan_cnt <= '0;
      scan_idx <= '0;
      pos_q    <= '0;
      step_q   <= 1'b0;
      seg_q    <= PAT_OFF ^ SEG_XOR;
      an_q     <= AN_XOR;
    end else begin
      if (bus.enable) begin
        step_cnt <= tick ? '0 : step_cnt + SW'(1);
      end
      if (tick) begin
        pos_q <= pos_nxt;
      end
      step_q <= tick;

      scan_cnt <= scan_wrap ? '0 : scan_cnt + CW'(1);
      if (scan_wrap) begin
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
      end

      // seg and an sample the same scan_idx so a digit never shows its neighbour's pattern.
      seg_q <= pat ^ SEG_XOR;
      an_q  <= an_hot ^ AN_XOR;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.pos  = pos_q;
  assign bus.step = step_q;

endmodule
